// File: rtl/tune_pkg.sv
// Shared types, entry layout, note half-periods (100 MHz clk) and the two tune tables.
// Entry layout is {half_period, dur}; dur==0 ends a tune, half_period==0 is a rest.
package tune_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TONE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int HP_W    = 20;
  localparam int DUR_W   = 4;
  localparam int IDX_W   = 6;
  localparam int ENTRY_W = HP_W + DUR_W;
  localparam int DEPTH   = 1 << IDX_W;

  localparam logic [HP_W-1:0] REST = 20'd0;
  localparam logic [HP_W-1:0] G4   = 20'd127_551;
  localparam logic [HP_W-1:0] A4   = 20'd113_636;
  localparam logic [HP_W-1:0] B4   = 20'd101_238;
  localparam logic [HP_W-1:0] C5   = 20'd95_556;
  localparam logic [HP_W-1:0] D5   = 20'd85_131;
  localparam logic [HP_W-1:0] E5   = 20'd75_843;
  localparam logic [HP_W-1:0] F5   = 20'd71_586;

  // Unlisted slots read as zero, which is also the end-of-tune marker.
  localparam logic [ENTRY_W-1:0] SNOWFALL_TUNE [DEPTH] = '{
    0:  {E5,   4'd4},
    1:  {D5,   4'd2},
    2:  {C5,   4'd2},
    3:  {D5,   4'd4},
    4:  {REST, 4'd2},
    5:  {E5,   4'd2},
    6:  {F5,   4'd2},
    7:  {E5,   4'd4},
    8:  {C5,   4'd4},
    9:  {B4,   4'd2},
    10: {A4,   4'd2},
    11: {G4,   4'd8},
    12: {REST, 4'd4},
    13: {C5,   4'd8},
    default: {REST, 4'd0}
  };

  localparam logic [ENTRY_W-1:0] TEST_TUNE [DEPTH] = '{
    0: {20'd3, 4'd2},
    1: {REST,  4'd1},
    2: {20'd1, 4'd1},
    default: {REST, 4'd0}
  };

endpackage

// File: rtl/tune_rom.sv
// Registered-read ROM holding the selected tune table; the caller presents the
// next note index so the entry is valid during the LOAD cycle.
module tune_rom
  import tune_pkg::*;
#(
  parameter int TUNE_SEL = 0
) (
  input  logic               clk,
  input  logic [IDX_W-1:0]   i_addr,
  output logic [ENTRY_W-1:0] o_data
);

  logic [ENTRY_W-1:0] r_data;

  generate
    if (TUNE_SEL == 1) begin : g_test
      always_ff @(posedge clk) begin
        r_data <= TEST_TUNE[i_addr];
      end
    end else begin : g_snowfall
      always_ff @(posedge clk) begin
        r_data <= SNOWFALL_TUNE[i_addr];
      end
    end
  endgenerate

  assign o_data = r_data;

endmodule

// File: rtl/tune_sequencer.sv
// Note-table player: FSM, tick/duration counters and tone divider producing a square wave.
// Define TUNE_REPEAT_EN to loop the tune forever instead of stopping in DONE.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int TUNE_SEL    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic             pause,
  output logic             song,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             r_state,    w_state_next;
  logic [IDX_W-1:0]   r_note_idx, w_note_idx_next;
  logic [HP_W-1:0]    r_hp,       w_hp_next;
  logic [DUR_W-1:0]   r_dur,      w_dur_next;
  logic [TW-1:0]      r_tick,     w_tick_next;
  logic [DUR_W-1:0]   r_dcnt,     w_dcnt_next;
  logic [HP_W-1:0]    r_div,      w_div_next;
  logic               r_phase,    w_phase_next;
  logic [GW-1:0]      r_gap,      w_gap_next;
  logic               r_song,     w_song_next;

  logic [ENTRY_W-1:0] w_rom_data;
  logic [HP_W-1:0]    w_rom_hp;
  logic [DUR_W-1:0]   w_rom_dur;
  logic               w_tone_last;

  tune_rom #(
    .TUNE_SEL (TUNE_SEL)
  ) u_rom (
    .clk    (clk),
    .i_addr (w_note_idx_next),
    .o_data (w_rom_data)
  );

  assign w_rom_hp    = w_rom_data[ENTRY_W-1:DUR_W];
  assign w_rom_dur   = w_rom_data[DUR_W-1:0];
  assign w_tone_last = (r_tick == TICK_LAST) && (r_dcnt == (r_dur - 4'd1));

  always_comb begin
    w_state_next    = r_state;
    w_note_idx_next = r_note_idx;
    w_hp_next       = r_hp;
    w_dur_next      = r_dur;
    w_tick_next     = r_tick;
    w_dcnt_next     = r_dcnt;
    w_div_next      = r_div;
    w_phase_next    = r_phase;
    w_gap_next      = r_gap;
    w_song_next     = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (play) begin
          w_state_next    = ST_LOAD;
          w_note_idx_next = '0;
        end
      end

      ST_LOAD: begin
        if (!pause) begin
          w_hp_next  = w_rom_hp;
          w_dur_next = w_rom_dur;
          if (w_rom_dur == '0) begin
`ifdef TUNE_REPEAT_EN
            w_state_next    = ST_LOAD;
            w_note_idx_next = '0;
`else
            w_state_next    = ST_DONE;
`endif
          end else begin
            w_state_next = ST_TONE;
            w_tick_next  = '0;
            w_dcnt_next  = '0;
            w_div_next   = '0;
            w_phase_next = 1'b0;
          end
        end
      end

      ST_TONE: begin
        if (!pause) begin
          if (r_tick == TICK_LAST) begin
            w_tick_next = '0;
            w_dcnt_next = r_dcnt + 4'd1;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
          // A zero half-period is a rest: the phase never leaves 0.
          if (r_hp != '0) begin
            if (r_div == (r_hp - 20'd1)) begin
              w_div_next   = '0;
              w_phase_next = ~r_phase;
            end else begin
              w_div_next = r_div + 20'd1;
            end
          end
          if (w_tone_last) begin
            w_tick_next  = '0;
            w_dcnt_next  = '0;
            w_div_next   = '0;
            w_phase_next = 1'b0;
            if (GAP_CYCLES == 0) begin
              w_state_next    = ST_LOAD;
              w_note_idx_next = r_note_idx + 1'b1;
            end else begin
              w_state_next = ST_GAP;
              w_gap_next   = '0;
            end
          end
        end
      end

      ST_GAP: begin
        if (!pause) begin
          if (r_gap == GAP_LAST) begin
            w_state_next    = ST_LOAD;
            w_note_idx_next = r_note_idx + 1'b1;
            w_gap_next      = '0;
          end else begin
            w_gap_next = r_gap + 1'b1;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    // The held phase survives a pause; only the registered output is muted.
    w_song_next = (w_state_next == ST_TONE) && w_phase_next && !pause;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_note_idx <= '0;
      r_hp       <= '0;
      r_dur      <= '0;
      r_tick     <= '0;
      r_dcnt     <= '0;
      r_div      <= '0;
      r_phase    <= 1'b0;
      r_gap      <= '0;
      r_song     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_note_idx <= w_note_idx_next;
      r_hp       <= w_hp_next;
      r_dur      <= w_dur_next;
      r_tick     <= w_tick_next;
      r_dcnt     <= w_dcnt_next;
      r_div      <= w_div_next;
      r_phase    <= w_phase_next;
      r_gap      <= w_gap_next;
      r_song     <= w_song_next;
    end
  end

  assign song     = r_song;
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done     = (r_state == ST_DONE);
  assign note_idx = r_note_idx;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed, table-driven bench for tune_sequencer on the 3-entry test tune
// (TICK_CYCLES=4, GAP_CYCLES=2); honours TUNE_REPEAT_EN for expectations.
module tb_tune_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       pause = 1'b0;
  logic       song;
  logic       busy;
  logic       done;
  logic [5:0] note_idx;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       rst;
    logic       ply;
    logic       pau;
    logic       e_song;
    logic       e_busy;
    logic       e_done;
    logic [5:0] e_idx;
    string      name;
  } vec_t;

  vec_t vq[$];

  tune_sequencer #(
    .TICK_CYCLES (4),
    .GAP_CYCLES  (2),
    .TUNE_SEL    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .pause    (pause),
    .song     (song),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic e_song, input logic e_busy,
                       input logic e_done, input logic [5:0] e_idx);
    total++;
    if ({song, busy, done, note_idx} !== {e_song, e_busy, e_done, e_idx}) begin
      bad++;
      $display("FAIL %s: got song=%0b busy=%0b done=%0b idx=%0d, want song=%0b busy=%0b done=%0b idx=%0d",
               name, song, busy, done, note_idx, e_song, e_busy, e_done, e_idx);
    end else begin
      $display("ok   %s: song=%0b busy=%0b done=%0b idx=%0d", name, song, busy, done, note_idx);
    end
  endtask

  task automatic add(input logic r, input logic p, input logic pa, input logic s,
                     input logic b, input logic d, input logic [5:0] idx, input string n);
    vec_t v;
    v.rst = r; v.ply = p; v.pau = pa;
    v.e_song = s; v.e_busy = b; v.e_done = d; v.e_idx = idx; v.name = n;
    vq.push_back(v);
  endtask

  // Inputs go in before the edge; outputs are checked 1 time unit after it.
  task automatic run_vectors();
    foreach (vq[i]) begin
      reset = vq[i].rst;
      play  = vq[i].ply;
      pause = vq[i].pau;
      @(posedge clk);
      #1;
      check(vq[i].name, vq[i].e_song, vq[i].e_busy, vq[i].e_done, vq[i].e_idx);
    end
    reset = 1'b0;
    play  = 1'b0;
    pause = 1'b0;
    vq.delete();
  endtask

  task automatic add_gap(input logic [5:0] idx);
    add(0, 0, 0, 0, 1, 0, idx, "gap");
    add(0, 0, 0, 0, 1, 0, idx, "gap");
  endtask

  logic tone0 [8];
  logic tone2 [4];

  initial begin
    tone0 = '{0, 0, 0, 1, 1, 1, 0, 0};
    tone2 = '{0, 1, 0, 1};

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset", 0, 0, 0, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle", 0, 0, 0, 0);
    end

    // Full tune: entry 0, rest, clk/2 entry, end marker
    add(0, 1, 0, 0, 1, 0, 0, "a_load0");
    for (int i = 0; i < 8; i++) add(0, 0, 0, tone0[i], 1, 0, 0, "a_tone0");
    add_gap(0);
    add(0, 0, 0, 0, 1, 0, 1, "a_load1");
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 1, "a_rest1");
    add_gap(1);
    add(0, 0, 0, 0, 1, 0, 2, "a_load2");
    for (int i = 0; i < 4; i++) add(0, 0, 0, tone2[i], 1, 0, 2, "a_tone2");
    add_gap(2);
    add(0, 0, 0, 0, 1, 0, 3, "a_load3");
`ifdef TUNE_REPEAT_EN
    add(0, 0, 0, 0, 1, 0, 0, "a_wrap_load0");
    add(0, 0, 0, 0, 1, 0, 0, "a_wrap_tone0");
`else
    add(0, 0, 0, 0, 0, 1, 3, "a_done");
    add(0, 0, 0, 0, 0, 1, 3, "a_done_hold");
`endif
    run_vectors();

`ifdef TUNE_REPEAT_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("repeat_reset", 0, 0, 0, 0);
    reset = 1'b0;
`endif

    // Restart, ignored play in TONE, 5-cycle pause, then reset in GAP
    add(0, 1, 0, 0, 1, 0, 0, "b_load0");
    add(0, 0, 0, 0, 1, 0, 0, "b_tone0");
    add(0, 0, 0, 0, 1, 0, 0, "b_tone0");
    add(0, 1, 0, 0, 1, 0, 0, "b_play_ignored");
    add(0, 0, 0, 1, 1, 0, 0, "b_tone0");
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 1, 0, 0, "b_paused");
    for (int i = 4; i < 8; i++) add(0, 0, 0, tone0[i], 1, 0, 0, "b_resumed");
    add(0, 0, 0, 0, 1, 0, 0, "b_gap0");
    add(1, 0, 0, 0, 0, 0, 0, "b_reset_in_gap");
    add(0, 1, 1, 0, 1, 0, 0, "c_play_pause_load");
    add(0, 0, 1, 0, 1, 0, 0, "c_hold_load");
    add(0, 0, 1, 0, 1, 0, 0, "c_hold_load");
    for (int i = 0; i < 8; i++) add(0, 0, 0, tone0[i], 1, 0, 0, "c_tone0");
    add_gap(0);
    add(0, 0, 0, 0, 1, 0, 1, "c_load1");
    run_vectors();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
